// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      HALT  = 2'd2,
      FAULT = 2'd3
   } pc_state_t;

   typedef enum logic [1:0] {
      SEQ    = 2'd0,
      BRANCH = 2'd1,
      JUMP   = 2'd2,
      JR     = 2'd3
   } pc_sel_t;

   localparam logic [31:0] PC_INCR = 32'd4;

   function automatic logic misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC target mux: sequential, branch, jump and jump-register.
module pc_next_sel
   import pc_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] branch_offset,
   input  logic [25:0] jump_index,
   input  logic [31:0] jr_target,
   input  pc_sel_t     sel,
   output logic [31:0] pc_plus4,
   output logic [31:0] pc_next
);

   always_comb begin
      pc_plus4 = pc + PC_INCR;
      pc_next  = pc_plus4;
      case (sel)
         SEQ:     pc_next = pc_plus4;
         BRANCH:  pc_next = pc_plus4 + branch_offset;
         JUMP:    pc_next = {pc_plus4[31:28], jump_index, 2'b00};
         JR:      pc_next = jr_target;
         default: pc_next = pc_plus4;
      endcase
   end

endmodule

// File: rtl/pc_control.sv
// PC register, boot/halt/fault sequencer and retired-instruction counter.
//
//   state | meaning
//   BOOT  | one cycle after reset release, PC parked at RESET_PC, no fetch
//   RUN   | fetching and retiring one instruction per unstalled cycle
//   HALT  | halt retired; PC frozen until reset
//   FAULT | misaligned jr trapped; epc holds its address until reset
module pc_control
   import pc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        branch,
   input  logic        zero,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jr,
   input  logic [31:0] jr_target,
   input  logic        halt,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_en,
   output logic        halted,
   output logic        fault,
   output logic [31:0] epc,
   output logic [31:0] instr_count
);

   pc_state_t   state_q;
   pc_state_t   state_d;
   pc_sel_t     sel;
   logic [31:0] pc_q;
   logic [31:0] pc_next;
   logic [31:0] epc_q;
   logic [31:0] cnt_q;
   logic        exec;
   logic        jr_fault;

   assign exec     = (state_q == RUN) && !stall;
   assign jr_fault = jr && misaligned(jr_target);

   always_comb begin
      sel = SEQ;
      if (jr)
         sel = JR;
      else if (jump)
         sel = JUMP;
      else if (branch && zero)
         sel = BRANCH;
   end

   pc_next_sel u_next_sel (
      .pc            (pc_q),
      .branch_offset (branch_offset),
      .jump_index    (jump_index),
      .jr_target     (jr_target),
      .sel           (sel),
      .pc_plus4      (pc_plus4),
      .pc_next       (pc_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= BOOT;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:    state_d = RUN;
         RUN: begin
            if (!stall) begin
               if (halt)
                  state_d = HALT;
               else if (jr_fault)
                  state_d = FAULT;
            end
         end
         HALT:    state_d = HALT;
         FAULT:   state_d = FAULT;
         default: state_d = BOOT;
      endcase
   end

   always_comb begin
      fetch_en = exec;
      halted   = (state_q == HALT);
      fault    = (state_q == FAULT);
   end

   // halt retires without moving PC; a faulting jr neither moves PC nor retires
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= RESET_PC;
         epc_q <= 32'd0;
         cnt_q <= 32'd0;
      end else if (exec) begin
         if (halt) begin
            cnt_q <= cnt_q + 32'd1;
         end else if (jr_fault) begin
            epc_q <= pc_q;
         end else begin
            pc_q  <= pc_next;
            cnt_q <= cnt_q + 32'd1;
         end
      end
   end

   assign pc          = pc_q;
   assign epc         = epc_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_pc_control.sv
// Scoreboard bench for pc_control: stimulus queues expected state, a monitor checks it.
module tb_pc_control;

   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, branch, zero, jump, jr, halt;
   logic [31:0] branch_offset, jr_target;
   logic [25:0] jump_index;
   logic [31:0] pc, pc_plus4, epc, instr_count;
   logic        fetch_en, halted, fault;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] cnt;
      logic [31:0] epc;
      logic        fe;
      logic        hl;
      logic        ft;
   } exp_t;

   exp_t q[$];

   pc_control #(.RESET_PC(RST_PC)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .branch        (branch),
      .zero          (zero),
      .branch_offset (branch_offset),
      .jump          (jump),
      .jump_index    (jump_index),
      .jr            (jr),
      .jr_target     (jr_target),
      .halt          (halt),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .fetch_en      (fetch_en),
      .halted        (halted),
      .fault         (fault),
      .epc           (epc),
      .instr_count   (instr_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic s, input logic b, input logic z, input logic [31:0] off,
                      input logic j, input logic [25:0] idx, input logic r,
                      input logic [31:0] tgt, input logic h);
      stall = s; branch = b; zero = z; branch_offset = off;
      jump = j; jump_index = idx; jr = r; jr_target = tgt; halt = h;
   endtask

   task automatic idle();
      drv(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic expect_s(input string n, input logic [31:0] p, input logic [31:0] c,
                           input logic fe, input logic hl, input logic ft, input logic [31:0] e);
      exp_t x;
      x.name = n; x.pc = p; x.cnt = c; x.epc = e; x.fe = fe; x.hl = hl; x.ft = ft;
      q.push_back(x);
   endtask

   // asserts reset mid-cycle, then walks through BOOT into the first RUN cycle
   task automatic do_reset();
      #1 rst_n = 1'b0;
      #1 expect_s("reset", RST_PC, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      rst_n = 1'b1;
      idle();
      expect_s("boot", RST_PC, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      expect_s("run0", RST_PC, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
   endtask

   // monitor: compares one queued expectation per falling edge
   initial begin
      exp_t x;
      logic [31:0] p4;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            x  = q.pop_front();
            p4 = x.pc + 32'd4;
            total++;
            if (pc !== x.pc || pc_plus4 !== p4 || instr_count !== x.cnt || epc !== x.epc ||
                fetch_en !== x.fe || halted !== x.hl || fault !== x.ft) begin
               bad++;
               $display("FAIL %s: got pc=%h p4=%h cnt=%0d epc=%h fe=%b h=%b f=%b exp pc=%h p4=%h cnt=%0d epc=%h fe=%b h=%b f=%b",
                        x.name, pc, pc_plus4, instr_count, epc, fetch_en, halted, fault,
                        x.pc, p4, x.cnt, x.epc, x.fe, x.hl, x.ft);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, exp finish before time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      idle();
      tick();
      do_reset();

      tick(); expect_s("seq1", 32'h0040_0004, 32'd1, 1'b1, 1'b0, 1'b0, 32'd0);
      tick(); expect_s("seq2", 32'h0040_0008, 32'd2, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
      drv(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h0000_0010, 1'b0);
      expect_s("seq3", 32'h0040_000C, 32'd3, 1'b1, 1'b0, 1'b0, 32'd0);

      tick();
      drv(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0);
      expect_s("jr_to_10", 32'h0000_0010, 32'd4, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
      drv(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h0000_0010, 1'b0);
      expect_s("branch_taken", 32'h0000_0004, 32'd5, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
      drv(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0);
      expect_s("jr_back_10", 32'h0000_0010, 32'd6, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
      drv(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h1000_0000, 1'b0);
      expect_s("branch_not_taken", 32'h0000_0014, 32'd7, 1'b1, 1'b0, 1'b0, 32'd0);

      tick();
      drv(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b1, 26'h000_0040, 1'b0, 32'd0, 1'b0);
      expect_s("jr_to_1000", 32'h1000_0000, 32'd8, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
      drv(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 26'h000_0080, 1'b0, 32'd0, 1'b0);
      expect_s("jump_wins", 32'h1000_0100, 32'd9, 1'b0, 1'b0, 1'b0, 32'd0);
      tick(); expect_s("stall2", 32'h1000_0100, 32'd9, 1'b0, 1'b0, 1'b0, 32'd0);
      tick(); expect_s("stall3", 32'h1000_0100, 32'd9, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      drv(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'h000_0080, 1'b0, 32'd0, 1'b0);
      expect_s("stall_release", 32'h1000_0100, 32'd9, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
      drv(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h0000_0020, 1'b0);
      expect_s("jump_after_stall", 32'h1000_0200, 32'd10, 1'b1, 1'b0, 1'b0, 32'd0);

      tick();
      drv(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h0000_0102, 1'b0);
      expect_s("jr_to_20", 32'h0000_0020, 32'd11, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
      drv(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b1, 26'h3FF_FFFF, 1'b1, 32'h0000_0040, 1'b1);
      expect_s("fault", 32'h0000_0020, 32'd11, 1'b0, 1'b0, 1'b1, 32'h0000_0020);
      tick();
      expect_s("fault_hold", 32'h0000_0020, 32'd11, 1'b0, 1'b0, 1'b1, 32'h0000_0020);
      tick();
      do_reset();

      drv(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h0000_0102, 1'b1);
      tick();
      idle();
      expect_s("halt_over_jr", RST_PC, 32'd1, 1'b0, 1'b1, 1'b0, 32'd0);
      tick();
      expect_s("halt_hold", RST_PC, 32'd1, 1'b0, 1'b1, 1'b0, 32'd0);
      tick();
      do_reset();

      drv(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      tick();
      idle();
      expect_s("pc_top", 32'hFFFF_FFFC, 32'd1, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
      expect_s("pc_wrap", 32'h0000_0000, 32'd2, 1'b1, 1'b0, 1'b0, 32'd0);

      for (int i = 0; i < 5 && q.size() > 0; i++)
         @(posedge clk);
      if (q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending, exp 0 pending", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
